// File: rtl/stopwatch_pkg.sv
// Shared types and constants for the MM:SS stopwatch sequencer.
package stopwatch_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_PAUSE = 2'd2
  } state_t;

  localparam int DIGIT_W    = 4;
  localparam int MOD_SEC_LO = 10;
  localparam int MOD_SEC_HI = 6;
  localparam int MOD_MIN_LO = 10;
  localparam int MOD_MIN_HI = 6;

endpackage

// File: rtl/stopwatch_if.sv
// Button-pulse and display bundle between the stopwatch sequencer and its user.
interface stopwatch_if;
  import stopwatch_pkg::*;

  logic               start_stop;
  logic               clear;
  logic               lap;
  logic               running;
  logic               tick;
  logic               rollover;
  logic               lap_active;
  logic [DIGIT_W-1:0] disp_min_hi;
  logic [DIGIT_W-1:0] disp_min_lo;
  logic [DIGIT_W-1:0] disp_sec_hi;
  logic [DIGIT_W-1:0] disp_sec_lo;

  modport master (
    output start_stop, clear, lap,
    input  running, tick, rollover, lap_active,
    input  disp_min_hi, disp_min_lo, disp_sec_hi, disp_sec_lo
  );

  modport slave (
    input  start_stop, clear, lap,
    output running, tick, rollover, lap_active,
    output disp_min_hi, disp_min_lo, disp_sec_hi, disp_sec_lo
  );

endinterface

// File: rtl/stopwatch_digit.sv
// sw_digit: one mod-MOD counter of the cascaded display chain.
module sw_digit #(
  parameter int MOD = 10,
  parameter int W   = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         en,
  input  logic         clr,
  output logic [W-1:0] q,
  output logic         tc
);

  localparam logic [W-1:0] LAST = W'(MOD - 1);

  assign tc = en && (q == LAST);

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      q <= '0;
    end else if (clr) begin
      q <= '0;
    end else if (en) begin
      q <= (q == LAST) ? '0 : q + 1'b1;
    end
  end

endmodule

// File: rtl/stopwatch_ctrl.sv
// Run/pause/clear sequencer driving an MM:SS digit chain from a TICK_DIV prescaler.
// Optional lap hold enabled by defining STOPWATCH_LAP_EN.
module stopwatch_ctrl
  import stopwatch_pkg::*;
#(
  parameter int TICK_DIV = 50_000_000
) (
  input logic        clk,
  input logic        reset,
  stopwatch_if.slave sw
);

  localparam int              TW         = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [TW-1:0]   PRESC_LAST = TW'(TICK_DIV - 1);
  localparam int              DISP_W     = 4 * DIGIT_W;

  state_t             r_state;
  logic               r_running;
  logic [TW-1:0]      r_presc;

  logic               w_tick;
  logic               w_clr;
  logic [DIGIT_W-1:0] w_sec_lo, w_sec_hi, w_min_lo, w_min_hi;
  logic               w_tc_sec_lo, w_tc_sec_hi, w_tc_min_lo, w_tc_min_hi;
  logic [DISP_W-1:0]  w_live;
  logic [DISP_W-1:0]  w_disp;
  logic               w_hold;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state   <= ST_IDLE;
      r_running <= 1'b0;
      r_presc   <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          r_presc <= '0;
          if (sw.start_stop) begin
            r_state   <= ST_RUN;
            r_running <= 1'b1;
          end
        end
        ST_RUN: begin
          // The pause edge still advances the prescaler so a tick on that edge is not replayed.
          r_presc <= (r_presc == PRESC_LAST) ? '0 : r_presc + 1'b1;
          if (sw.start_stop) begin
            r_state   <= ST_PAUSE;
            r_running <= 1'b0;
          end
        end
        ST_PAUSE: begin
          if (sw.clear) begin
            r_state   <= ST_IDLE;
            r_running <= 1'b0;
            r_presc   <= '0;
          end else if (sw.start_stop) begin
            r_state   <= ST_RUN;
            r_running <= 1'b1;
          end
        end
        default: begin
          r_state   <= ST_IDLE;
          r_running <= 1'b0;
          r_presc   <= '0;
        end
      endcase
    end
  end

  assign w_tick = (r_state == ST_RUN) && (r_presc == PRESC_LAST);
  assign w_clr  = (r_state == ST_PAUSE) && sw.clear;

  sw_digit #(.MOD(MOD_SEC_LO), .W(DIGIT_W)) u_sec_lo (
    .clk(clk), .reset(reset), .en(w_tick),      .clr(w_clr), .q(w_sec_lo), .tc(w_tc_sec_lo)
  );
  sw_digit #(.MOD(MOD_SEC_HI), .W(DIGIT_W)) u_sec_hi (
    .clk(clk), .reset(reset), .en(w_tc_sec_lo), .clr(w_clr), .q(w_sec_hi), .tc(w_tc_sec_hi)
  );
  sw_digit #(.MOD(MOD_MIN_LO), .W(DIGIT_W)) u_min_lo (
    .clk(clk), .reset(reset), .en(w_tc_sec_hi), .clr(w_clr), .q(w_min_lo), .tc(w_tc_min_lo)
  );
  sw_digit #(.MOD(MOD_MIN_HI), .W(DIGIT_W)) u_min_hi (
    .clk(clk), .reset(reset), .en(w_tc_min_lo), .clr(w_clr), .q(w_min_hi), .tc(w_tc_min_hi)
  );

  assign w_live = {w_min_hi, w_min_lo, w_sec_hi, w_sec_lo};

`ifdef STOPWATCH_LAP_EN
  logic              r_hold;
  logic [DISP_W-1:0] r_lap;

  // NOTE: the lap snapshot is reset too, so the display never shows X after a held reset release.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_hold <= 1'b0;
      r_lap  <= '0;
    end else if (w_clr) begin
      r_hold <= 1'b0;
    end else if ((r_state == ST_RUN) && sw.lap) begin
      r_hold <= !r_hold;
      if (!r_hold) begin
        r_lap <= w_live;
      end
    end
  end

  assign w_hold = r_hold;
  assign w_disp = r_hold ? r_lap : w_live;
`else
  assign w_hold = 1'b0;
  assign w_disp = w_live;
`endif

  // The whole chain is at 59:59 exactly when the top digit's terminal count fires.
  assign sw.rollover    = w_tc_min_hi;
  assign sw.tick        = w_tick;
  assign sw.running     = r_running;
  assign sw.lap_active  = w_hold;
  assign sw.disp_min_hi = w_disp[4*DIGIT_W-1:3*DIGIT_W];
  assign sw.disp_min_lo = w_disp[3*DIGIT_W-1:2*DIGIT_W];
  assign sw.disp_sec_hi = w_disp[2*DIGIT_W-1:DIGIT_W];
  assign sw.disp_sec_lo = w_disp[DIGIT_W-1:0];

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Self-checking bench for stopwatch_ctrl; honours STOPWATCH_LAP_EN when defined.
module tb_stopwatch_ctrl;
  import stopwatch_pkg::*;

  localparam int DIV = 4;

  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   errors = 0;

  stopwatch_if sw4 ();
  stopwatch_if sw1 ();

  stopwatch_ctrl #(.TICK_DIV(DIV)) dut (.clk(clk), .reset(reset), .sw(sw4));
  stopwatch_ctrl #(.TICK_DIV(1))   dut1 (.clk(clk), .reset(reset), .sw(sw1));

  always #5 clk = ~clk;

  // Reference model: elapsed running edges since the last clear; display = seconds derived by division.
  bit m_run, m_pause, m_hold;
  int m_cyc, m_snap;

  function automatic int m_live();
    return (m_cyc / DIV) % 3600;
  endfunction

  function automatic logic [15:0] bcd(input int s);
    return {4'(s / 600), 4'((s / 60) % 10), 4'((s % 60) / 10), 4'(s % 10)};
  endfunction

  task automatic model_reset();
    m_run = 0; m_pause = 0; m_hold = 0; m_cyc = 0; m_snap = 0;
  endtask

  task automatic model_edge(input bit ss, input bit cl, input bit lp);
    int live_pre;
    bit run_pre;
    live_pre = m_live();
    run_pre  = m_run;
    if (run_pre) m_cyc++;
`ifdef STOPWATCH_LAP_EN
    if (run_pre && lp) begin
      if (!m_hold) m_snap = live_pre;
      m_hold = !m_hold;
    end
`endif
    if (!m_run && !m_pause) begin
      if (ss) m_run = 1;
    end else if (m_run) begin
      if (ss) begin m_run = 0; m_pause = 1; end
    end else begin
      if (cl) begin
        m_pause = 0; m_cyc = 0; m_hold = 0;
      end else if (ss) begin
        m_pause = 0; m_run = 1;
      end
    end
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] disp4();
    return {sw4.disp_min_hi, sw4.disp_min_lo, sw4.disp_sec_hi, sw4.disp_sec_lo};
  endfunction

  task automatic check_all(input string tag);
    bit          e_tick;
    logic [15:0] e_disp;
    e_tick = m_run && ((m_cyc % DIV) == DIV - 1);
    e_disp = m_hold ? bcd(m_snap) : bcd(m_live());
    check({tag, ".running"},  sw4.running,    m_run);
    check({tag, ".tick"},     sw4.tick,       e_tick);
    check({tag, ".rollover"}, sw4.rollover,   e_tick && (m_live() == 3599));
    check({tag, ".lap"},      sw4.lap_active, m_hold);
    check({tag, ".disp"},     disp4(),        e_disp);
  endtask

  // Applies one cycle of pulses, lets the edge happen, then checks 1 time unit later.
  task automatic cycle(input bit ss, input bit cl, input bit lp, input string tag);
    sw4.start_stop = ss; sw4.clear = cl; sw4.lap = lp;
    @(posedge clk);
    model_edge(ss, cl, lp);
    #1;
    sw4.start_stop = 0; sw4.clear = 0; sw4.lap = 0;
    check_all(tag);
  endtask

  initial begin
    logic [15:0] frozen;
    reset = 1'b1;
    sw4.start_stop = 0; sw4.clear = 0; sw4.lap = 0;
    sw1.start_stop = 0; sw1.clear = 0; sw1.lap = 0;
    model_reset();
    #12;
    check_all("reset");
    check("reset.dut1_disp", {sw1.disp_min_hi, sw1.disp_min_lo, sw1.disp_sec_hi, sw1.disp_sec_lo}, 16'h0000);
    reset = 1'b0;

    // TICK_DIV=1 wrap: 3599 edges after start reach 59:59, next edge wraps.
    sw1.start_stop = 1;
    @(posedge clk); #1;
    sw1.start_stop = 0;
    check("div1.start_tick", sw1.tick, 1'b1);
    repeat (3599) @(posedge clk);
    #1;
    check("div1.5959", {sw1.disp_min_hi, sw1.disp_min_lo, sw1.disp_sec_hi, sw1.disp_sec_lo}, 16'h5959);
    check("div1.rollover_hi", sw1.rollover, 1'b1);
    @(posedge clk); #1;
    check("div1.wrap", {sw1.disp_min_hi, sw1.disp_min_lo, sw1.disp_sec_hi, sw1.disp_sec_lo}, 16'h0000);
    check("div1.rollover_lo", sw1.rollover, 1'b0);
    check("div1.running", sw1.running, 1'b1);

    // First tick latency and ten seconds of counting.
    cycle(1, 0, 0, "t1.start");
    repeat (3) cycle(0, 0, 0, "t1.pre");
    cycle(0, 0, 0, "t1.first");
    check("t1.sec_lo1", sw4.disp_sec_lo, 4'd1);
    repeat (36) cycle(0, 0, 0, "t1.run");
    check("t1.0010", disp4(), 16'h0010);
    check("t1.running", sw4.running, 1'b1);

    // Pause keeps digits and prescaler fraction, resume continues from them.
    repeat (2) cycle(0, 0, 0, "t2.run");
    cycle(1, 0, 0, "t2.pause");
    frozen = disp4();
    repeat (10) cycle(0, 0, 0, "t2.paused");
    check("t2.frozen", disp4(), frozen);
    cycle(1, 0, 0, "t2.resume");
    repeat (6) cycle(0, 0, 0, "t2.after");

    // start_stop+clear in PAUSE: clear wins. clear in RUN ignored.
    cycle(1, 0, 0, "t4.pause");
    cycle(1, 1, 0, "t4.clear");
    check("t4.zero", disp4(), 16'h0000);
    check("t4.idle", sw4.running, 1'b0);
    cycle(1, 0, 0, "t4.start");
    repeat (14) cycle(0, 0, 0, "t4.run");
    cycle(0, 1, 0, "t4.clear_run");
    check("t4.still_running", sw4.running, 1'b1);

    // Lap hold at 00:05 while live runs to 00:08.
    cycle(1, 0, 0, "t6.pause");
    cycle(0, 1, 0, "t6.clear");
    cycle(1, 0, 0, "t6.start");
    repeat (20) cycle(0, 0, 0, "t6.run");
    cycle(0, 0, 1, "t6.lap_on");
    repeat (11) cycle(0, 0, 0, "t6.held");
`ifdef STOPWATCH_LAP_EN
    check("t6.held_disp", disp4(), 16'h0005);
    check("t6.lap_active", sw4.lap_active, 1'b1);
`else
    check("t6.live_disp", disp4(), 16'h0008);
    check("t6.lap_active", sw4.lap_active, 1'b0);
`endif
    cycle(0, 0, 1, "t6.lap_off");
    check("t6.release", disp4(), 16'h0008);

    // Asynchronous reset mid-cycle while running at 00:07.
    cycle(1, 0, 0, "t5.pause");
    cycle(0, 1, 0, "t5.clear");
    cycle(1, 0, 0, "t5.start");
    repeat (28) cycle(0, 0, 0, "t5.run");
    check("t5.0007", disp4(), 16'h0007);
    #3;
    reset = 1'b1;
    #1;
    model_reset();
    check("t5.async_disp", disp4(), 16'h0000);
    check("t5.async_running", sw4.running, 1'b0);
    check_all("t5.async");
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    repeat (5) cycle(0, 0, 0, "t5.idle");

    // Random pulses against the model.
    for (int i = 0; i < 3000; i++) begin
      cycle($urandom_range(0, 19) == 0, $urandom_range(0, 7) == 0,
            $urandom_range(0, 9) == 0, "rand");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
